// File: rtl/rtc_bus_cycle_if.sv
// -----------------------------------------------------------------------------
// rtc_bus_cycle_if
// Purpose : Bundles the request/response handshake from the RTC sequencing FSM
//           together with the RTC's multiplexed address/data bus pins.
// Signals :
//   req, wr_nrd, addr[7:0], wdata[7:0]   request from the sequencer
//   busy, ack, rdata[7:0], rdata_valid   status/response to the sequencer
//   cs_n, rd_n, wr_n, a_d                RTC bus control (active-low strobes)
//   ad_out[7:0], ad_oe                   AD bus drive value and output enable
//   ad_in[7:0]                           AD bus sampled value
// Modports:
//   master : sequencer/bus side (drives requests and the sampled AD value)
//   slave  : bus-cycle generator (rtc_bus_cycle)
// -----------------------------------------------------------------------------
interface rtc_bus_cycle_if;
   logic       req;
   logic       wr_nrd;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       busy;
   logic       ack;
   logic [7:0] rdata;
   logic       rdata_valid;
   logic       cs_n;
   logic       rd_n;
   logic       wr_n;
   logic       a_d;
   logic [7:0] ad_out;
   logic       ad_oe;
   logic [7:0] ad_in;

   modport master (
      output req, wr_nrd, addr, wdata, ad_in,
      input  busy, ack, rdata, rdata_valid,
      input  cs_n, rd_n, wr_n, a_d, ad_out, ad_oe
   );

   modport slave (
      input  req, wr_nrd, addr, wdata, ad_in,
      output busy, ack, rdata, rdata_valid,
      output cs_n, rd_n, wr_n, a_d, ad_out, ad_oe
   );
endinterface

// File: rtl/rtc_bus_cycle.sv
// -----------------------------------------------------------------------------
// rtc_bus_cycle
// Purpose : Turns one register-access request into a full two-phase bus cycle
//           on the RTC's multiplexed AD port: an address phase (always a write
//           strobe, a_d=0) followed by a data phase (a_d=1) that either writes
//           wdata or reads the AD bus. Timing of each phase is programmable.
// Ports   :
//   clk  in  system clock, rising edge
//   clr  in  synchronous active-low reset
//   bus  slave modport of rtc_bus_cycle_if (request, response, RTC bus pins)
// Parameters (cycles, 1..255, 0 behaves as 1):
//   T_SETUP  AD/a_d stable before the strobe, per phase
//   T_PULSE  cs_n and the strobe held low, per phase
//   T_HOLD   AD/a_d held after the strobe rises, per phase
//   T_GAP    idle cycles between address hold and data setup
// -----------------------------------------------------------------------------
module rtc_bus_cycle #(
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 8,
   parameter int T_HOLD  = 2,
   parameter int T_GAP   = 4
) (
   input  logic            clk,
   input  logic            clr,
   rtc_bus_cycle_if.slave  bus
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_A_SETUP, ST_A_PULSE, ST_A_HOLD, ST_GAP,
      ST_D_SETUP, ST_D_PULSE, ST_D_HOLD, ST_DONE
   } state_t;

   // The counter counts down to 0, so a state lasting N cycles loads N-1.
   localparam logic [7:0] SETUP_RL = (T_SETUP > 1) ? 8'(T_SETUP - 1) : 8'd0;
   localparam logic [7:0] PULSE_RL = (T_PULSE > 1) ? 8'(T_PULSE - 1) : 8'd0;
   localparam logic [7:0] HOLD_RL  = (T_HOLD  > 1) ? 8'(T_HOLD  - 1) : 8'd0;
   localparam logic [7:0] GAP_RL   = (T_GAP   > 1) ? 8'(T_GAP   - 1) : 8'd0;

   function automatic logic [7:0] reload_for(input state_t s);
      case (s)
         ST_A_SETUP, ST_D_SETUP: reload_for = SETUP_RL;
         ST_A_PULSE, ST_D_PULSE: reload_for = PULSE_RL;
         ST_A_HOLD,  ST_D_HOLD:  reload_for = HOLD_RL;
         ST_GAP:                 reload_for = GAP_RL;
         default:                reload_for = 8'd0;
      endcase
   endfunction

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       wr_nrd_q, wr_nrd_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] cap_q, cap_d;

   logic       cs_n_q, cs_n_d;
   logic       rd_n_q, rd_n_d;
   logic       wr_n_q, wr_n_d;
   logic       a_d_q, a_d_d;
   logic [7:0] ad_out_q, ad_out_d;
   logic       ad_oe_q, ad_oe_d;
   logic       busy_q, busy_d;
   logic       ack_q, ack_d;
   logic [7:0] rdata_q, rdata_d;
   logic       rdata_valid_q, rdata_valid_d;

   // State register: state, counter, latches and registered outputs.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 8'd0;
         wr_nrd_q      <= 1'b0;
         addr_q        <= 8'd0;
         wdata_q       <= 8'd0;
         cap_q         <= 8'd0;
         cs_n_q        <= 1'b1;
         rd_n_q        <= 1'b1;
         wr_n_q        <= 1'b1;
         a_d_q         <= 1'b0;
         ad_out_q      <= 8'd0;
         ad_oe_q       <= 1'b0;
         busy_q        <= 1'b0;
         ack_q         <= 1'b0;
         rdata_q       <= 8'd0;
         rdata_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wr_nrd_q      <= wr_nrd_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         cap_q         <= cap_d;
         cs_n_q        <= cs_n_d;
         rd_n_q        <= rd_n_d;
         wr_n_q        <= wr_n_d;
         a_d_q         <= a_d_d;
         ad_out_q      <= ad_out_d;
         ad_oe_q       <= ad_oe_d;
         busy_q        <= busy_d;
         ack_q         <= ack_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      wr_nrd_d = wr_nrd_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cap_d    = cap_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               state_d  = ST_A_SETUP;
               wr_nrd_d = bus.wr_nrd;
               addr_d   = bus.addr;
               wdata_d  = bus.wdata;
            end
         end
         ST_A_SETUP: if (cnt_q == 8'd0) state_d = ST_A_PULSE;
         ST_A_PULSE: if (cnt_q == 8'd0) state_d = ST_A_HOLD;
         ST_A_HOLD:  if (cnt_q == 8'd0) state_d = ST_GAP;
         ST_GAP:     if (cnt_q == 8'd0) state_d = ST_D_SETUP;
         ST_D_SETUP: if (cnt_q == 8'd0) state_d = ST_D_PULSE;
         ST_D_PULSE: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_D_HOLD;
               // Sample the bus on the last strobe cycle, while rd_n is still low.
               if (!wr_nrd_q) cap_d = bus.ad_in;
            end
         end
         ST_D_HOLD:  if (cnt_q == 8'd0) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // Reload on every state change so each timed state starts fresh.
      if (state_d != state_q)   cnt_d = reload_for(state_d);
      else if (cnt_q != 8'd0)   cnt_d = cnt_q - 8'd1;
      else                      cnt_d = cnt_q;
   end

   // Output logic: decoded from the state being entered, so the registered
   // outputs change on the same edge as the state.
   always_comb begin
      cs_n_d        = 1'b1;
      rd_n_d        = 1'b1;
      wr_n_d        = 1'b1;
      a_d_d         = 1'b0;
      ad_out_d      = 8'd0;
      ad_oe_d       = 1'b0;
      busy_d        = 1'b0;
      ack_d         = 1'b0;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      case (state_d)
         ST_A_SETUP, ST_A_PULSE, ST_A_HOLD: begin
            busy_d   = 1'b1;
            ad_oe_d  = 1'b1;
            ad_out_d = addr_d;
            if (state_d == ST_A_PULSE) begin
               cs_n_d = 1'b0;
               wr_n_d = 1'b0;
            end
         end
         ST_GAP: begin
            busy_d = 1'b1;
            a_d_d  = 1'b1;
         end
         ST_D_SETUP, ST_D_PULSE, ST_D_HOLD: begin
            busy_d = 1'b1;
            a_d_d  = 1'b1;
            if (wr_nrd_d) begin
               ad_oe_d  = 1'b1;
               ad_out_d = wdata_d;
            end
            if (state_d == ST_D_PULSE) begin
               cs_n_d = 1'b0;
               if (wr_nrd_d) wr_n_d = 1'b0;
               else          rd_n_d = 1'b0;
            end
         end
         ST_DONE: begin
            ack_d = 1'b1;
            if (!wr_nrd_d) begin
               rdata_d       = cap_q;
               rdata_valid_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.cs_n        = cs_n_q;
   assign bus.rd_n        = rd_n_q;
   assign bus.wr_n        = wr_n_q;
   assign bus.a_d         = a_d_q;
   assign bus.ad_out      = ad_out_q;
   assign bus.ad_oe       = ad_oe_q;
   assign bus.busy        = busy_q;
   assign bus.ack         = ack_q;
   assign bus.rdata       = rdata_q;
   assign bus.rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
module tb_rtc_bus_cycle;

   logic clk = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   rtc_bus_cycle_if bus_s ();
   rtc_bus_cycle_if bus_f ();

   rtc_bus_cycle dut_s (
      .clk (clk),
      .clr (clr),
      .bus (bus_s.slave)
   );

   rtc_bus_cycle #(
      .T_SETUP (1),
      .T_PULSE (1),
      .T_HOLD  (1),
      .T_GAP   (1)
   ) dut_f (
      .clk (clk),
      .clr (clr),
      .bus (bus_f.slave)
   );

   // Slave device model: valid data only while the read strobe is low.
   logic [7:0] rd_val_s = 8'h00;
   logic [7:0] rd_val_f = 8'h00;
   assign bus_s.ad_in = !bus_s.rd_n ? rd_val_s : 8'hEE;
   assign bus_f.ad_in = !bus_f.rd_n ? rd_val_f : 8'hEE;

   // Observation mux: sel=0 watches the default-timing DUT, sel=1 the fast one.
   logic sel = 1'b0;
   wire       m_cs_n  = sel ? bus_f.cs_n  : bus_s.cs_n;
   wire       m_rd_n  = sel ? bus_f.rd_n  : bus_s.rd_n;
   wire       m_wr_n  = sel ? bus_f.wr_n  : bus_s.wr_n;
   wire       m_a_d   = sel ? bus_f.a_d   : bus_s.a_d;
   wire       m_ad_oe = sel ? bus_f.ad_oe : bus_s.ad_oe;
   wire [7:0] m_ad    = sel ? bus_f.ad_out : bus_s.ad_out;
   wire       m_busy  = sel ? bus_f.busy  : bus_s.busy;
   wire       m_ack   = sel ? bus_f.ack   : bus_s.ack;

   int checks = 0;
   int failures = 0;

   int cs_lo_a, cs_lo_d, wr_lo_a, wr_lo_d, rd_lo_a, rd_lo_d;
   int oe_d, overlap, ad_err, busy_gap;
   int lat;
   int extra_ack, extra_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs from just after the accept edge until ack, collecting per-cycle stats.
   // reinj>0 pulses a competing request (addr 0x33) on the default DUT at that cycle.
   task automatic run_cycle(input logic [7:0] ea, input logic [7:0] ed,
                            input int reinj, output int l);
      cs_lo_a = 0; cs_lo_d = 0; wr_lo_a = 0; wr_lo_d = 0; rd_lo_a = 0; rd_lo_d = 0;
      oe_d = 0; overlap = 0; ad_err = 0; busy_gap = 0;
      l = -1;
      for (int i = 1; i <= 100; i++) begin
         if (reinj > 0 && i == reinj) begin
            bus_s.req = 1'b1; bus_s.addr = 8'h33; bus_s.wdata = 8'h99;
         end
         if (reinj > 0 && i == reinj + 1) bus_s.req = 1'b0;
         tick();
         if (!m_cs_n && !m_a_d) cs_lo_a++;
         if (!m_cs_n &&  m_a_d) cs_lo_d++;
         if (!m_wr_n && !m_a_d) wr_lo_a++;
         if (!m_wr_n &&  m_a_d) wr_lo_d++;
         if (!m_rd_n && !m_a_d) rd_lo_a++;
         if (!m_rd_n &&  m_a_d) rd_lo_d++;
         if (!m_rd_n && !m_wr_n) overlap++;
         if (!m_cs_n && m_rd_n && m_wr_n) overlap++;
         if (m_cs_n && (!m_rd_n || !m_wr_n)) overlap++;
         if (m_ad_oe && !m_a_d && m_ad != ea) ad_err++;
         if (m_ad_oe &&  m_a_d && m_ad != ed) ad_err++;
         if (m_ad_oe && m_a_d) oe_d++;
         if (!m_ack && !m_busy) busy_gap++;
         if (m_ack) begin
            l = i;
            break;
         end
      end
   endtask

   initial begin
      bus_s.req = 1'b0; bus_s.wr_nrd = 1'b0; bus_s.addr = 8'h00; bus_s.wdata = 8'h00;
      bus_f.req = 1'b0; bus_f.wr_nrd = 1'b0; bus_f.addr = 8'h00; bus_f.wdata = 8'h00;

      // Reset state
      clr = 1'b0;
      tick(); tick(); tick();
      check("rst_ctrl", {bus_s.cs_n, bus_s.rd_n, bus_s.wr_n, bus_s.a_d, bus_s.ad_oe}, 32'b11100);
      check("rst_stat", {bus_s.busy, bus_s.ack, bus_s.rdata_valid}, 32'b000);
      check("rst_data", {bus_s.ad_out, bus_s.rdata}, 32'h0000);
      clr = 1'b1;
      tick();

      // 1: write 0x45 to 0x21; pins change after accept to prove latching
      bus_s.req = 1'b1; bus_s.wr_nrd = 1'b1; bus_s.addr = 8'h21; bus_s.wdata = 8'h45;
      tick();
      check("t1_accept", {bus_s.busy, bus_s.cs_n, bus_s.ad_oe, bus_s.a_d, bus_s.ad_out}, {4'b1110, 8'h21});
      bus_s.req = 1'b0; bus_s.addr = 8'hFF; bus_s.wdata = 8'h00; bus_s.wr_nrd = 1'b0;
      run_cycle(8'h21, 8'h45, 0, lat);
      $display("T1 write lat=%0d cs_a=%0d cs_d=%0d wr_a=%0d wr_d=%0d", lat, cs_lo_a, cs_lo_d, wr_lo_a, wr_lo_d);
      check("t1_lat", lat, 28);
      check("t1_cs_a", cs_lo_a, 8);
      check("t1_cs_d", cs_lo_d, 8);
      check("t1_wr_a", wr_lo_a, 8);
      check("t1_wr_d", wr_lo_d, 8);
      check("t1_rd", rd_lo_a + rd_lo_d, 0);
      check("t1_oe_d", oe_d, 12);
      check("t1_ad_err", ad_err, 0);
      check("t1_overlap", overlap, 0);
      check("t1_busy_gap", busy_gap, 0);
      check("t1_done", {bus_s.busy, bus_s.rdata_valid}, 32'b00);
      tick();

      // 2: read 0x22, device returns 0x59
      bus_s.req = 1'b1; bus_s.wr_nrd = 1'b0; bus_s.addr = 8'h22; rd_val_s = 8'h59;
      tick();
      bus_s.req = 1'b0;
      run_cycle(8'h22, 8'h00, 0, lat);
      $display("T2 read lat=%0d rd_d=%0d wr_a=%0d rdata=%0h", lat, rd_lo_d, wr_lo_a, bus_s.rdata);
      check("t2_lat", lat, 28);
      check("t2_wr_a", wr_lo_a, 8);
      check("t2_wr_d", wr_lo_d, 0);
      check("t2_rd_a", rd_lo_a, 0);
      check("t2_rd_d", rd_lo_d, 8);
      check("t2_cs_d", cs_lo_d, 8);
      check("t2_oe_d", oe_d, 0);
      check("t2_overlap", overlap, 0);
      check("t2_rdata", {bus_s.rdata_valid, bus_s.rdata}, {1'b1, 8'h59});
      tick();
      check("t2_hold", {bus_s.rdata_valid, bus_s.rdata}, {1'b0, 8'h59});

      // 3: competing request 5 cycles into a write is ignored
      bus_s.req = 1'b1; bus_s.wr_nrd = 1'b1; bus_s.addr = 8'h21; bus_s.wdata = 8'h46;
      tick();
      bus_s.req = 1'b0;
      run_cycle(8'h21, 8'h46, 5, lat);
      extra_ack = 0; extra_busy = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus_s.ack) extra_ack++;
         if (bus_s.busy) extra_busy++;
      end
      $display("T3 ignore lat=%0d ad_err=%0d extra_ack=%0d extra_busy=%0d", lat, ad_err, extra_ack, extra_busy);
      check("t3_lat", lat, 28);
      check("t3_ad_err", ad_err, 0);
      check("t3_extra_ack", extra_ack, 0);
      check("t3_extra_busy", extra_busy, 0);

      // 4: reset during the 4th D_PULSE cycle of a read
      bus_s.req = 1'b1; bus_s.wr_nrd = 1'b0; bus_s.addr = 8'h2B; rd_val_s = 8'h77;
      tick();
      bus_s.req = 1'b0;
      for (int i = 0; i < 21; i++) tick();
      check("t4_in_pulse", {bus_s.cs_n, bus_s.rd_n, bus_s.a_d}, 32'b001);
      clr = 1'b0;
      tick();
      $display("T4 abort cs_n=%0b rd_n=%0b wr_n=%0b oe=%0b busy=%0b ack=%0b", bus_s.cs_n, bus_s.rd_n, bus_s.wr_n, bus_s.ad_oe, bus_s.busy, bus_s.ack);
      check("t4_strobes", {bus_s.cs_n, bus_s.rd_n, bus_s.wr_n, bus_s.ad_oe}, 32'b1110);
      check("t4_stat", {bus_s.busy, bus_s.ack, bus_s.rdata_valid}, 32'b000);
      check("t4_rdata", bus_s.rdata, 32'h00);
      clr = 1'b1;
      bus_s.req = 1'b1; bus_s.wr_nrd = 1'b1; bus_s.addr = 8'h44; bus_s.wdata = 8'h55;
      tick();
      check("t4_reaccept", bus_s.busy, 1);

      // 5: req held high -> second cycle after exactly one IDLE cycle
      run_cycle(8'h44, 8'h55, 0, lat);
      check("t5_lat1", lat, 28);
      tick();
      check("t5_idle", {bus_s.busy, bus_s.ack}, 32'b00);
      tick();
      check("t5_rebusy", bus_s.busy, 1);
      bus_s.req = 1'b0;
      run_cycle(8'h44, 8'h55, 0, lat);
      $display("T5 b2b lat2=%0d cs_d=%0d", lat, cs_lo_d);
      check("t5_lat2", lat, 28);
      check("t5_cs_d", cs_lo_d, 8);

      // 6: all timings 1, read 0x5A returning 0x3C
      sel = 1'b1;
      bus_f.req = 1'b1; bus_f.wr_nrd = 1'b0; bus_f.addr = 8'h5A; rd_val_f = 8'h3C;
      tick();
      bus_f.req = 1'b0;
      run_cycle(8'h5A, 8'h00, 0, lat);
      $display("T6 fast read lat=%0d rdata=%0h", lat, bus_f.rdata);
      check("t6_lat", lat, 7);
      check("t6_cs_a", cs_lo_a, 1);
      check("t6_cs_d", cs_lo_d, 1);
      check("t6_rd_d", rd_lo_d, 1);
      check("t6_overlap", overlap, 0);
      check("t6_rdata", {bus_f.rdata_valid, bus_f.rdata}, {1'b1, 8'h3C});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
